// File: rtl/semaforo_param.sv
// Two-road traffic-light controller with parametrised phase durations, a road-B demand latch
// and a blinking-yellow night mode. State and counter advance only on the prescaler tick.
//
// state     | meaning
// VERDE_A   | road A green, road B red; holds at end until road B demand
// AMARELO_A | road A yellow, road B red
// VERM_1    | all-red clearance before road B
// VERDE_B   | road B green, road A red
// AMARELO_B | road B yellow, road A red
// VERM_2    | all-red clearance before road A; also the night-exit landing state
// NOITE_ON  | night mode, both yellow lamps on
// NOITE_OFF | night mode, all lamps off
module semaforo_param #(
  parameter int unsigned T_VERDE_A    = 4,
  parameter int unsigned T_VERDE_B    = 3,
  parameter int unsigned T_AMARELO    = 2,
  parameter int unsigned T_VERM_TOTAL = 1,
  parameter int unsigned T_PISCA      = 1,
  parameter int unsigned CW           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       modo,
  input  logic       req_b,
  output logic [2:0] luz_a,
  output logic [2:0] luz_b,
  output logic [2:0] fase
);

  typedef enum logic [2:0] {
    VERDE_A   = 3'd0,
    AMARELO_A = 3'd1,
    VERM_1    = 3'd2,
    VERDE_B   = 3'd3,
    AMARELO_B = 3'd4,
    VERM_2    = 3'd5,
    NOITE_ON  = 3'd6,
    NOITE_OFF = 3'd7
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic            req_pend;
  logic            at_end;
  logic            night;
  logic            enter_b;

  // Terminal count of the phase counter for each state (duration minus one).
  function automatic logic [CW-1:0] last_cnt(input state_t s);
    case (s)
      VERDE_A:             return CW'(T_VERDE_A - 1);
      VERDE_B:             return CW'(T_VERDE_B - 1);
      AMARELO_A, AMARELO_B: return CW'(T_AMARELO - 1);
      VERM_1, VERM_2:      return CW'(T_VERM_TOTAL - 1);
      default:             return CW'(T_PISCA - 1);
    endcase
  endfunction

  // Lamp pattern {luz_a, luz_b}, each {verde, amarelo, vermelho}.
  function automatic logic [5:0] lamps(input state_t s);
    case (s)
      VERDE_A:   return {3'b100, 3'b001};
      AMARELO_A: return {3'b010, 3'b001};
      VERM_1:    return {3'b001, 3'b001};
      VERDE_B:   return {3'b001, 3'b100};
      AMARELO_B: return {3'b001, 3'b010};
      VERM_2:    return {3'b001, 3'b001};
      NOITE_ON:  return {3'b010, 3'b010};
      default:   return {3'b000, 3'b000};
    endcase
  endfunction

  assign at_end  = (cnt == last_cnt(state));
  assign night   = (state == NOITE_ON) || (state == NOITE_OFF);
  assign enter_b = (state_nx == VERDE_B) && (state != VERDE_B);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (tick) begin
      if (night && !modo) begin
        state_nx = VERM_2;
        cnt_nx   = '0;
      end else if (!night && modo) begin
        state_nx = NOITE_ON;
        cnt_nx   = '0;
      end else if (!at_end) begin
        cnt_nx = cnt + 1'b1;
      end else begin
        cnt_nx = '0;
        case (state)
          VERDE_A: begin
            // Without demand the green is held and the counter saturates.
            if (req_pend || req_b) begin
              state_nx = AMARELO_A;
            end else begin
              cnt_nx = cnt;
            end
          end
          AMARELO_A: state_nx = VERM_1;
          VERM_1:    state_nx = VERDE_B;
          VERDE_B:   state_nx = AMARELO_B;
          AMARELO_B: state_nx = VERM_2;
          VERM_2:    state_nx = VERDE_A;
          NOITE_ON:  state_nx = NOITE_OFF;
          NOITE_OFF: state_nx = NOITE_ON;
          default: begin
            state_nx = VERM_2;
            cnt_nx   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= VERDE_A;
      cnt      <= '0;
      req_pend <= 1'b0;
      luz_a    <= 3'b100;
      luz_b    <= 3'b001;
      fase     <= 3'd0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      {luz_a, luz_b} <= lamps(state_nx);
      fase           <= 3'(state_nx);
      // Entering VERDE_B serves the demand; a new request on that same edge is dropped.
      req_pend       <= enter_b ? 1'b0 : (req_pend | req_b);
    end
  end

endmodule

// File: tb/tb_semaforo_param.sv
// Directed and random checks of semaforo_param against a phase/elapsed-tick reference model.
module tb_semaforo_param;

  localparam int T_VERDE_A    = 4;
  localparam int T_VERDE_B    = 3;
  localparam int T_AMARELO    = 2;
  localparam int T_VERM_TOTAL = 1;
  localparam int T_PISCA      = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       modo;
  logic       req_b;
  logic [2:0] luz_a;
  logic [2:0] luz_b;
  logic [2:0] fase;

  int errors = 0;
  int checks = 0;

  int m_ph;
  int m_el;
  bit m_pend;

  semaforo_param dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .modo  (modo),
    .req_b (req_b),
    .luz_a (luz_a),
    .luz_b (luz_b),
    .fase  (fase)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int p);
    case (p)
      0:       return T_VERDE_A;
      1, 4:    return T_AMARELO;
      2, 5:    return T_VERM_TOTAL;
      3:       return T_VERDE_B;
      default: return T_PISCA;
    endcase
  endfunction

  function automatic logic [2:0] exp_a(input int p);
    case (p)
      0:       return 3'b100;
      1, 6:    return 3'b010;
      7:       return 3'b000;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] exp_b(input int p);
    case (p)
      3:       return 3'b100;
      4, 6:    return 3'b010;
      7:       return 3'b000;
      default: return 3'b001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph   = 0;
    m_el   = 0;
    m_pend = 0;
  endtask

  task automatic model_step();
    int  prev;
    bit  pend_in;
    prev    = m_ph;
    pend_in = m_pend;
    if (tick) begin
      if (m_ph >= 6) begin
        if (!modo) begin
          m_ph = 5;
          m_el = 0;
        end else if (m_el + 1 >= T_PISCA) begin
          m_ph = (m_ph == 6) ? 7 : 6;
          m_el = 0;
        end else begin
          m_el++;
        end
      end else if (modo) begin
        m_ph = 6;
        m_el = 0;
      end else if (m_el + 1 < dur(m_ph)) begin
        m_el++;
      end else if (m_ph == 0 && !(pend_in || req_b)) begin
        m_el = m_el;
      end else begin
        m_ph = (m_ph + 1) % 6;
        m_el = 0;
      end
    end
    m_pend = (m_ph == 3 && prev != 3) ? 1'b0 : (pend_in || req_b);
  endtask

  task automatic compare_model();
    chk("fase", fase, 3'(m_ph));
    chk("luz_a", luz_a, exp_a(m_ph));
    chk("luz_b", luz_b, exp_b(m_ph));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until(input logic [2:0] target, input string tag);
    int n;
    n = 0;
    while (fase !== target && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, fase, target);
  endtask

  logic [2:0] seq [13];
  logic [2:0] prev_a;
  logic [2:0] prev_b;
  int         edge_n;

  initial begin
    rst   = 1'b0;
    tick  = 1'b0;
    modo  = 1'b0;
    req_b = 1'b0;
    model_reset();
    #12;
    chk("reset_fase", fase, 3'd0);
    chk("reset_luz_a", luz_a, 3'b100);
    chk("reset_luz_b", luz_b, 3'b001);

    // Default day sequence with continuous demand.
    seq = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
    tick  = 1'b1;
    req_b = 1'b1;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      cycle();
      chk($sformatf("seq_edge%0d", i + 1), fase, seq[i]);
    end

    // No demand: VERDE_A holds; a one-clock pulse releases it.
    req_b = 1'b0;
    apply_reset();
    repeat (20) cycle();
    chk("hold_no_demand", fase, 3'd0);
    req_b = 1'b1;
    cycle();
    req_b = 1'b0;
    chk("pulse_exit", fase, 3'd1);
    run_until(3'd3, "reach_verde_b");
    run_until(3'd0, "back_verde_a");
    repeat (10) cycle();
    chk("pend_cleared", fase, 3'd0);

    // Sparse tick: VERDE_A spans 16 clocks and lamps hold between ticks.
    req_b  = 1'b1;
    tick   = 1'b0;
    apply_reset();
    edge_n = 0;
    while (fase === 3'd0 && edge_n < 40) begin
      edge_n++;
      tick   = (edge_n % 4 == 0);
      prev_a = luz_a;
      prev_b = luz_b;
      cycle();
      if (!tick) begin
        chk("hold_luz_a", luz_a, prev_a);
        chk("hold_luz_b", luz_b, prev_b);
      end
    end
    chk("verde_a_16clk", 3'(edge_n == 16), 3'd1);

    // Night mode entered from VERDE_B cnt=1, then exit through VERM_2.
    tick = 1'b1;
    apply_reset();
    run_until(3'd3, "night_pre_vb");
    cycle();
    modo = 1'b1;
    cycle();
    chk("night_on", fase, 3'd6);
    chk("night_on_a", luz_a, 3'b010);
    chk("night_on_b", luz_b, 3'b010);
    cycle();
    chk("night_off", fase, 3'd7);
    chk("night_off_a", luz_a, 3'b000);
    cycle();
    chk("night_on2", fase, 3'd6);
    cycle();
    chk("night_off2", fase, 3'd7);
    modo = 1'b0;
    cycle();
    chk("night_exit_verm2", fase, 3'd5);
    cycle();
    chk("night_exit_verde_a", fase, 3'd0);

    // Asynchronous reset in the middle of AMARELO_B.
    apply_reset();
    run_until(3'd4, "reach_amarelo_b");
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_fase", fase, 3'd0);
    chk("async_rst_luz_a", luz_a, 3'b100);
    chk("async_rst_luz_b", luz_b, 3'b001);
    @(negedge clk);
    rst = 1'b1;
    seq = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("post_rst_edge%0d", i + 1), fase, seq[i]);
    end

    // Random traffic against the model plus lamp legality.
    for (int i = 0; i < 10000; i++) begin
      tick  = ($urandom_range(0, 2) != 0);
      req_b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) modo = ~modo;
      cycle();
      chk("safety_two_green", 3'(luz_a[2] & luz_b[2]), 3'd0);
      chk("legal_luz_a", 3'(luz_a inside {3'b100, 3'b010, 3'b001, 3'b000}), 3'd1);
      chk("legal_luz_b", 3'(luz_b inside {3'b100, 3'b010, 3'b001, 3'b000}), 3'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
